// File: rtl/ic_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill controller: FSM encoding,
// default line geometry and bus field widths.
package ic_refill_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RECV   = 3'd2,
        ST_REFILL = 3'd3,
        ST_DONE   = 3'd4
    } ic_state_e;

    localparam int LINE_WORDS_DEF = 8;
    localparam int RD_LEN_W       = 8;
    localparam int PTAG_W         = 20;

    // Clear the low byte-offset bits of an address.
    function automatic logic [31:0] align_addr(input logic [31:0] addr, input int unsigned low_bits);
        return (addr >> low_bits) << low_bits;
    endfunction

endpackage

// File: rtl/ic_line_buf.sv
// Line assembly buffer: LINE_WORDS x 32-bit words written by beat index,
// read back either one selected word or the whole flattened line.
module ic_line_buf #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [31:0]             wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [31:0]             rd_word,
    output logic [32*LINE_WORDS-1:0] line
);

    logic [31:0] mem_r [LINE_WORDS];

    // Beat storage; words not written by a burst keep their previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (we) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Flatten storage into the line bus, word 0 in the LSBs.
    always_comb begin
        line = {(32*LINE_WORDS){1'b0}};
        for (int i = 0; i < LINE_WORDS; i++) begin
            line[32*i +: 32] = mem_r[i];
        end
    end

    assign rd_word = mem_r[rd_idx];

endmodule

// File: rtl/ic_refill_ctrl.sv
// I-cache miss / uncached-fetch controller: issues a bus read burst, assembles
// the line, writes it back and returns the requested word. Optional miss
// statistics counter enabled by defining IC_MISS_STAT_EN.
module ic_refill_ctrl
    import ic_refill_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int OFFSET_W   = $clog2(LINE_WORDS*4)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     req_valid,
    input  logic [31:0]              req_pc,
    input  logic                     inst_uncached,
    input  logic [PTAG_W-1:0]        inst_tag,
    input  logic                     hit,
    output logic                     stallreq,
    output logic                     rd_req,
    output logic [31:0]              rd_addr,
    output logic [RD_LEN_W-1:0]      rd_len,
    input  logic                     rd_addr_ok,
    input  logic [31:0]              rd_data,
    input  logic                     rd_valid,
    input  logic                     rd_last,
    output logic                     refill_we,
    output logic [31:0]              refill_addr,
    output logic [32*LINE_WORDS-1:0] refill_line,
    output logic [31:0]              inst_o,
    output logic                     inst_o_valid
`ifdef IC_MISS_STAT_EN
    ,
    output logic [31:0]              miss_cnt
`endif
);

    localparam int WORD_W = OFFSET_W - 2;
    localparam int CNT_W  = WORD_W + 1;

    ic_state_e           state_r;
    ic_state_e           state_s;
    logic                miss_s;
    logic                stall_s;
    logic                load_s;
    logic                enter_done_s;
    logic                busy_s;
    logic [31:0]         paddr_s;
    logic                uncached_r;
    logic [WORD_W-1:0]   woff_r;
    logic                kill_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [31:0]         rd_addr_r;
    logic [RD_LEN_W-1:0] rd_len_r;
    logic [31:0]         refill_addr_r;
    logic [31:0]         inst_o_r;
    logic                inst_o_valid_r;
    logic                buf_we_s;
    logic [WORD_W-1:0]   buf_rd_idx_s;
    logic [31:0]         buf_word_s;
    logic [31:0]         inst_next_s;
    logic                unused_pc_s;

    assign paddr_s     = {inst_tag, req_pc[31-PTAG_W:0]};
    assign unused_pc_s = ^req_pc[31:32-PTAG_W];
    assign miss_s      = req_valid & (~hit | inst_uncached) & ~flush;
    assign busy_s      = (state_r == ST_REQ) || (state_r == ST_RECV) || (state_r == ST_REFILL);

    // Next-state decode and stall generation.
    always_comb begin
        state_s      = state_r;
        stall_s      = 1'b0;
        load_s       = 1'b0;
        enter_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_s = miss_s;
                if (miss_s) begin
                    load_s  = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                if (rd_addr_ok) begin
                    state_s = ST_RECV;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RECV: begin
                stall_s = 1'b1;
                if (rd_valid && rd_last) begin
                    if (uncached_r) begin
                        state_s      = ST_DONE;
                        enter_done_s = 1'b1;
                    end else begin
                        state_s = ST_REFILL;
                    end
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_REFILL: begin
                stall_s      = 1'b1;
                state_s      = ST_DONE;
                enter_done_s = 1'b1;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the missing access and the bus request it needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uncached_r    <= 1'b0;
            woff_r        <= {WORD_W{1'b0}};
            rd_addr_r     <= 32'h0000_0000;
            rd_len_r      <= {RD_LEN_W{1'b0}};
            refill_addr_r <= 32'h0000_0000;
        end else if (load_s) begin
            uncached_r    <= inst_uncached;
            woff_r        <= paddr_s[OFFSET_W-1:2];
            rd_addr_r     <= inst_uncached ? {paddr_s[31:2], 2'b00} : align_addr(paddr_s, OFFSET_W);
            rd_len_r      <= inst_uncached ? {RD_LEN_W{1'b0}} : RD_LEN_W'(LINE_WORDS - 1);
            refill_addr_r <= align_addr(paddr_s, OFFSET_W);
        end
    end

    // Beats past the end of the line are not written and do not advance the count.
    assign buf_we_s = (state_r == ST_RECV) && rd_valid && (cnt_r < CNT_W'(LINE_WORDS));

    // Beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (buf_we_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Kill flag: a flush during the miss only suppresses the returned word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_r <= 1'b0;
        end else if (state_s == ST_IDLE) begin
            kill_r <= 1'b0;
        end else if (flush && busy_s) begin
            kill_r <= 1'b1;
        end
    end

    ic_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (WORD_W)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (buf_we_s),
        .wr_idx  (cnt_r[WORD_W-1:0]),
        .wr_data (rd_data),
        .rd_idx  (buf_rd_idx_s),
        .rd_word (buf_word_s),
        .line    (refill_line)
    );

    // A single-beat uncached read finishes in the cycle its beat arrives, so bypass the buffer.
    assign buf_rd_idx_s = uncached_r ? {WORD_W{1'b0}} : woff_r;
    assign inst_next_s  = (uncached_r && (cnt_r == {CNT_W{1'b0}})) ? rd_data : buf_word_s;

    // Returned instruction word, presented during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_o_r       <= 32'h0000_0000;
            inst_o_valid_r <= 1'b0;
        end else begin
            if (enter_done_s) begin
                inst_o_r <= inst_next_s;
            end
            inst_o_valid_r <= enter_done_s & ~(kill_r | flush);
        end
    end

`ifdef IC_MISS_STAT_EN
    logic [31:0] miss_cnt_r;

    // Miss statistics, wrapping counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt_r <= 32'h0000_0000;
        end else if (load_s) begin
            miss_cnt_r <= miss_cnt_r + 32'd1;
        end
    end

    assign miss_cnt = miss_cnt_r;
`endif

    assign stallreq     = stall_s;
    assign rd_req       = (state_r == ST_REQ);
    assign rd_addr      = rd_addr_r;
    assign rd_len       = rd_len_r;
    assign refill_we    = (state_r == ST_REFILL);
    assign refill_addr  = refill_addr_r;
    assign inst_o       = inst_o_r;
    assign inst_o_valid = inst_o_valid_r;

endmodule

// File: doc/ic_refill_ctrl.md
# ic_refill_ctrl

Instruction-cache miss and uncached-fetch controller for the IC stage. It consumes the IC-stage request (virtual PC, physical tag, uncached flag) and the tag-compare hit result. On a miss or uncached access it stalls the front end and issues a read burst on the instruction bus port. It collects the returned beats into a line buffer, writes the line into the cache arrays, and returns the requested instruction word. It is the consumer end of the PC→IT→IC translation path.

## Interface
Parameters:
- LINE_WORDS, 8, words per cache line (power of two, 2..16)
- OFFSET_W, $clog2(LINE_WORDS*4), byte-offset bits within a line

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush (exception/branch redirect)
- req_valid  in  1  IC-stage access valid (already masked for TLB refill/invalid)
- req_pc  in  32  virtual PC of the access
- inst_uncached  in  1  access is uncached
- inst_tag  in  20  physical page tag
- hit  in  1  tag-compare hit for req_pc
- stallreq  out  1  front-end stall request
- rd_req  out  1  bus read request
- rd_addr  out  32  bus read address
- rd_len  out  8  beats minus one
- rd_addr_ok  in  1  bus accepted the request
- rd_data  in  32  read beat data
- rd_valid  in  1  read beat valid
- rd_last  in  1  final beat
- refill_we  out  1  write line into data/tag arrays (one cycle)
- refill_addr  out  32  physical line-aligned address of refilled line
- refill_line  out  32*LINE_WORDS  line data, word 0 in LSBs
- inst_o  out  32  fetched instruction word
- inst_o_valid  out  1  inst_o valid (one cycle)
- miss_cnt  out  32  miss counter (only with IC_MISS_STAT_EN)

## Operation
- Physical address: paddr = {inst_tag, req_pc[11:0]}.
- miss = req_valid & (~hit | inst_uncached) & ~flush.
- FSM states: IDLE, REQ, RECV, REFILL, DONE.
- IDLE: on miss, latch paddr, uncached flag and word offset, then go to REQ. stallreq = miss (combinational in IDLE).
- REQ: rd_req=1. Cached: rd_addr = paddr with low OFFSET_W bits cleared, rd_len = LINE_WORDS-1. Uncached: rd_addr = paddr & ~3, rd_len = 0. Address and length are held stable until rd_addr_ok. On rd_addr_ok, go to RECV.
- RECV: on each rd_valid, store rd_data at the beat counter and increment the counter. Beats beyond LINE_WORDS are dropped. On rd_valid & rd_last: cached goes to REFILL, uncached goes to DONE. An early rd_last still goes to REFILL; missing words are left unchanged.
- REFILL: refill_we=1 for one cycle, with refill_addr = latched line address. Then go to DONE.
- DONE: inst_o = uncached ? first beat : buffer[latched word offset]. inst_o_valid=1 unless killed. Go to IDLE.
- stallreq=1 in REQ, RECV and REFILL. stallreq=0 in DONE.
- Flush while in REQ/RECV/REFILL: set the kill flag. The bus transaction always completes. A cached line is still written. inst_o_valid is suppressed in DONE. The kill flag clears on entry to IDLE.
- Flush in IDLE: no miss is latched that cycle.

## Timing
- Reset values: state IDLE; stallreq 0 (IDLE with req_valid 0); rd_req 0; rd_addr 0; rd_len 0; refill_we 0; refill_addr 0; refill_line 0; inst_o 0; inst_o_valid 0; kill 0; beat counter 0; miss_cnt 0.
- Reset asserted mid-transaction returns to IDLE immediately. The bus is expected to be reset with it.
- Minimum cached miss, with rd_addr_ok in the REQ cycle and one beat per cycle: IDLE(miss) → REQ → LINE_WORDS RECV cycles → REFILL → DONE. stallreq drops in the DONE cycle.
- Minimum uncached access: IDLE → REQ → RECV(1) → DONE.
- rd_valid may have gaps. The counter advances only on rd_valid.
- A hit in IDLE produces no activity and no stall.

## Configuration
- IC_MISS_STAT_EN defined: miss_cnt increments by 1 on every IDLE→REQ transition, including uncached accesses. It wraps at 2^32.
- IC_MISS_STAT_EN undefined: the miss_cnt port and counter are absent.

## Structure
- Shared package/defines: FSM state encoding, LINE_WORDS default, bus rd_len width, physical-tag width 20.
- One natural sub-module: ic_line_buf. It is a LINE_WORDS×32 beat-indexed write buffer with word-select read.

## Test plan
- Hit: req_valid=1, hit=1, inst_uncached=0 → stallreq=0, rd_req never asserted.
- Cached miss: req_pc=0x0000_1014, inst_tag=0x00ABC, LINE_WORDS=8 → rd_addr=0x00AB_C000 wait, expected 0x00ABC000, rd_len=7. Beats 0x100..0x107 → refill_we with refill_addr=0x00ABC000; inst_o=0x105, inst_o_valid=1.
- Uncached: inst_uncached=1, paddr 0x1FC0_0008 → rd_addr=0x1FC00008, rd_len=0, one beat 0xDEADBEEF → inst_o=0xDEADBEEF, no refill_we.
- Flush during RECV after beat 3 → burst completes, refill_we=1, inst_o_valid=0, stallreq low after DONE.
- rd_addr_ok delayed 5 cycles and rd_valid with gaps → rd_addr/rd_len stable, stallreq held high throughout, correct line assembled.
- IC_MISS_STAT_EN: 3 misses and 2 hits → miss_cnt=3. Async rst mid-RECV → state IDLE, all outputs at reset values.
